// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the CPU memory stage and a
// BUS_W-wide data bus. It accepts one request at a time and issues one or two
// bus beats with byte strobes. Load data is reassembled, masked and then
// zero- or sign-extended.
// Optional feature macro: LSU_MISALIGNED_EN. When it is defined, accesses
// that cross a bus-word boundary are split into two beats. When it is not
// defined, such accesses are rejected with o_err.
module lsu_align #(
  parameter int ADDR_W = 32,
  parameter int BUS_W  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [BUS_W-1:0]        i_wdata,
  input  logic                    i_wr,
  input  logic [1:0]              i_length,
  input  logic                    i_signed,
  output logic                    o_rsp_valid,
  output logic [BUS_W-1:0]        o_rdata,
  output logic                    o_err,
  output logic                    o_bus_valid,
  input  logic                    i_bus_ready,
  output logic [ADDR_W-1:0]       o_bus_addr,
  output logic                    o_bus_wr,
  output logic [BUS_W-1:0]        o_bus_wdata,
  output logic [BUS_W/8-1:0]      o_bus_strb,
  input  logic                    i_bus_rvalid,
  input  logic [BUS_W-1:0]        i_bus_rdata
);

  localparam int BYTES = BUS_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_WAIT0 = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
`ifdef LSU_MISALIGNED_EN
    , S_BEAT1 = 3'd5
    , S_WAIT1 = 3'd6
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BUS_W-1:0]    wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [1:0]          length_q, length_d;
  logic                signed_q, signed_d;
  logic [BUS_W-1:0]    rdata0_q, rdata0_d;
`ifdef LSU_MISALIGNED_EN
  logic                cross_q, cross_d;
  logic [BUS_W-1:0]    rdata1_q, rdata1_d;
`endif

  // ---------------------------------------------------------------------
  // Request decode, evaluated on the incoming request
  // ---------------------------------------------------------------------
  logic [OFS_W-1:0] req_ofs;
  logic [3:0]       req_size;
  logic [4:0]       req_end;
  logic             req_cross;
  logic             req_len_bad;
  logic             req_illegal;
  logic             req_fire;

  assign req_ofs     = i_addr[OFS_W-1:0];
  assign req_size    = 4'd1 << i_length;
  assign req_end     = {{(5-OFS_W){1'b0}}, req_ofs} + {1'b0, req_size};
  assign req_cross   = (req_end > 5'(BYTES));
  assign req_len_bad = (i_length == 2'b11) && (BUS_W == 32);
`ifdef LSU_MISALIGNED_EN
  assign req_illegal = req_len_bad;
`else
  assign req_illegal = req_len_bad | req_cross;
`endif
  assign req_fire    = i_req_valid & o_req_ready;

  // ---------------------------------------------------------------------
  // Datapath derived from the registered request
  // ---------------------------------------------------------------------
  logic [OFS_W-1:0]  ofs_r;
  logic [3:0]        size_r;
  logic [BYTES-1:0]  byte_en;
  logic [BUS_W-1:0]  data_mask;
  logic [BUS_W-1:0]  wdata_m;
  logic [BYTES-1:0]  msb_sel;
  logic [BUS_W-1:0]  rd_low;
  logic [BUS_W-1:0]  rd_ext;
  logic              rd_sign;
  logic [ADDR_W-1:0] beat0_addr;
  logic [BUS_W-1:0]  beat0_wdata;
  logic [BYTES-1:0]  beat0_strb;

  assign ofs_r      = addr_q[OFS_W-1:0];
  assign size_r     = 4'd1 << length_q;
  assign beat0_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  // Per-byte lane enables (byte index below access size) and the matching bit mask.
  // Also picks out the sign bit, which is the MSB of the top byte of the access.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
    assign byte_en[gi]          = (4'(gi) < size_r);
    assign data_mask[gi*8 +: 8] = {8{byte_en[gi]}};
    assign msb_sel[gi]          = (4'(gi) == (size_r - 4'd1)) & rd_low[gi*8+7];
    assign rd_ext[gi*8 +: 8]    = byte_en[gi] ? rd_low[gi*8 +: 8] : {8{rd_sign}};
  end

  assign wdata_m = wdata_q & data_mask;
  assign rd_sign = signed_q & (|msb_sel);

`ifdef LSU_MISALIGNED_EN
  logic [2*BUS_W-1:0] wide;
  logic [2*BYTES-1:0] strb2;
  logic [ADDR_W-1:0]  beat1_addr;
  logic [BUS_W-1:0]   beat1_wdata;
  logic [BYTES-1:0]   beat1_strb;

  assign wide        = {{BUS_W{1'b0}}, wdata_m} << {ofs_r, 3'b000};
  assign strb2       = {{BYTES{1'b0}}, byte_en} << ofs_r;
  assign beat0_wdata = wide[BUS_W-1:0];
  assign beat1_wdata = wide[2*BUS_W-1:BUS_W];
  assign beat0_strb  = strb2[BYTES-1:0];
  assign beat1_strb  = strb2[2*BYTES-1:BYTES];
  assign beat1_addr  = beat0_addr + ADDR_W'(BYTES);
  assign rd_low      = BUS_W'({rdata1_q, rdata0_q} >> {ofs_r, 3'b000});
`else
  // Only non-crossing accesses get here, so everything fits in one bus word.
  assign beat0_wdata = wdata_m << {ofs_r, 3'b000};
  assign beat0_strb  = byte_en << ofs_r;
  assign rd_low      = rdata0_q >> {ofs_r, 3'b000};
`endif

  // ---------------------------------------------------------------------
  // Next-state and capture logic
  // ---------------------------------------------------------------------
  // Sequences the beats and captures request fields and returned bus data.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    length_d = length_q;
    signed_d = signed_q;
    rdata0_d = rdata0_q;
`ifdef LSU_MISALIGNED_EN
    cross_d  = cross_q;
    rdata1_d = rdata1_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          wr_d     = i_wr;
          length_d = i_length;
          signed_d = i_signed;
          rdata0_d = '0;
`ifdef LSU_MISALIGNED_EN
          cross_d  = req_cross;
          rdata1_d = '0;
`endif
          state_d  = req_illegal ? S_ERR : S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (i_bus_ready) begin
          if (!wr_q) begin
            state_d = S_WAIT0;
          end else begin
`ifdef LSU_MISALIGNED_EN
            state_d = cross_q ? S_BEAT1 : S_RESP;
`else
            state_d = S_RESP;
`endif
          end
        end
      end
      S_WAIT0: begin
        if (i_bus_rvalid) begin
          rdata0_d = i_bus_rdata;
`ifdef LSU_MISALIGNED_EN
          state_d  = cross_q ? S_BEAT1 : S_RESP;
`else
          state_d  = S_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGNED_EN
      S_BEAT1: begin
        if (i_bus_ready) begin
          state_d = wr_q ? S_RESP : S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (i_bus_rvalid) begin
          rdata1_d = i_bus_rdata;
          state_d  = S_RESP;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset aborts any transfer in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      length_q <= 2'b00;
      signed_q <= 1'b0;
      rdata0_q <= '0;
`ifdef LSU_MISALIGNED_EN
      cross_q  <= 1'b0;
      rdata1_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      length_q <= length_d;
      signed_q <= signed_d;
      rdata0_q <= rdata0_d;
`ifdef LSU_MISALIGNED_EN
      cross_q  <= cross_d;
      rdata1_q <= rdata1_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Outputs, decoded from state; bus fields are zero when no beat is offered
  // ---------------------------------------------------------------------
  // Drives the bus and response ports from the current state and registered request.
  always_comb begin
    o_req_ready = (state_q == S_IDLE) & ~i_rst;
    o_rsp_valid = (state_q == S_RESP) | (state_q == S_ERR);
    o_err       = (state_q == S_ERR);
    o_rdata     = ((state_q == S_RESP) && !wr_q) ? rd_ext : '0;
    o_bus_valid = 1'b0;
    o_bus_addr  = '0;
    o_bus_wr    = 1'b0;
    o_bus_wdata = '0;
    o_bus_strb  = '0;
    if (state_q == S_BEAT0) begin
      o_bus_valid = 1'b1;
      o_bus_addr  = beat0_addr;
      o_bus_wr    = wr_q;
      o_bus_wdata = wr_q ? beat0_wdata : '0;
      o_bus_strb  = wr_q ? beat0_strb  : '0;
    end
`ifdef LSU_MISALIGNED_EN
    if (state_q == S_BEAT1) begin
      o_bus_valid = 1'b1;
      o_bus_addr  = beat1_addr;
      o_bus_wr    = wr_q;
      o_bus_wdata = wr_q ? beat1_wdata : '0;
      o_bus_strb  = wr_q ? beat1_strb  : '0;
    end
`endif
  end

endmodule

// File: tb/tb_lsu_align.sv
// Testbench for lsu_align (BUS_W=32). It runs a table of directed requests
// and then a few hand-written sequences: reset state, reset during WAIT0,
// and a bus stall. Split-access vectors are included when LSU_MISALIGNED_EN
// is defined; otherwise the same crossing accesses are expected to error.
module tb_lsu_align;

  localparam int ADDR_W = 32;
  localparam int BUS_W  = 32;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_req_valid;
  logic               o_req_ready;
  logic [ADDR_W-1:0]  i_addr;
  logic [BUS_W-1:0]   i_wdata;
  logic               i_wr;
  logic [1:0]         i_length;
  logic               i_signed;
  logic               o_rsp_valid;
  logic [BUS_W-1:0]   o_rdata;
  logic               o_err;
  logic               o_bus_valid;
  logic               i_bus_ready;
  logic [ADDR_W-1:0]  o_bus_addr;
  logic               o_bus_wr;
  logic [BUS_W-1:0]   o_bus_wdata;
  logic [BUS_W/8-1:0] o_bus_strb;
  logic               i_bus_rvalid;
  logic [BUS_W-1:0]   i_bus_rdata;

  always #5 clk = ~clk;

  lsu_align #(.ADDR_W(ADDR_W), .BUS_W(BUS_W)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_wr         (i_wr),
    .i_length     (i_length),
    .i_signed     (i_signed),
    .o_rsp_valid  (o_rsp_valid),
    .o_rdata      (o_rdata),
    .o_err        (o_err),
    .o_bus_valid  (o_bus_valid),
    .i_bus_ready  (i_bus_ready),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wr     (o_bus_wr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_strb   (o_bus_strb),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        err;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] w1;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  function automatic vec_t mk(
    input logic wr, input logic [1:0] len, input logic sgn,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rd0, input logic [31:0] rd1,
    input logic err, input int beats,
    input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] w0,
    input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] w1,
    input logic [31:0] rdata, input int lat);
    vec_t v;
    v.wr = wr; v.len = len; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rd0 = rd0; v.rd1 = rd1; v.err = err; v.beats = beats;
    v.a0 = a0; v.s0 = s0; v.w0 = w0; v.a1 = a1; v.s1 = s1; v.w1 = w1;
    v.rdata = rdata; v.lat = lat;
    return v;
  endfunction

  vec_t vecs[$];

  // Runs one request with i_bus_ready high; read data returns one cycle
  // after each read beat is accepted. Cycle 0 is the acceptance cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int beats;
    bit done;
    bit pend;
    logic [31:0] pdata;
    @(negedge clk);
    chk($sformatf("v%0d_req_ready", idx), o_req_ready, 1'b1);
    i_addr = v.addr; i_wdata = v.wdata; i_wr = v.wr;
    i_length = v.len; i_signed = v.sgn; i_req_valid = 1'b1;
    cyc = 0; beats = 0; done = 0; pend = 0; pdata = '0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      i_req_valid  = 1'b0;
      i_bus_rvalid = 1'b0;
      i_bus_rdata  = '0;
      if (pend) begin
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = pdata;
        pend = 0;
      end
      if (o_bus_valid) begin
        if (beats < v.beats) begin
          chk($sformatf("v%0d_b%0d_addr", idx, beats), o_bus_addr, (beats == 0) ? v.a0 : v.a1);
          chk($sformatf("v%0d_b%0d_wr", idx, beats), o_bus_wr, v.wr);
          chk($sformatf("v%0d_b%0d_strb", idx, beats), o_bus_strb, (beats == 0) ? v.s0 : v.s1);
          chk($sformatf("v%0d_b%0d_wdata", idx, beats), o_bus_wdata, (beats == 0) ? v.w0 : v.w1);
          if (!v.wr) begin
            pend  = 1;
            pdata = (beats == 0) ? v.rd0 : v.rd1;
          end
        end
        beats++;
      end
      if (o_rsp_valid) begin
        done = 1;
        chk($sformatf("v%0d_err", idx), o_err, v.err);
        chk($sformatf("v%0d_rdata", idx), o_rdata, v.rdata);
        chk($sformatf("v%0d_latency", idx), cyc, v.lat);
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL v%0d_timeout: got no response within %0d cycles, required one", idx, cyc);
    end
    chk($sformatf("v%0d_beats", idx), beats, v.beats);
    $display("txn %0d: wr=%0d len=%0d sgn=%0d addr=0x%08h beats=%0d err=%0d rdata=0x%08h cyc=%0d",
             idx, v.wr, v.len, v.sgn, v.addr, beats, o_err, o_rdata, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_addr = '0; i_wdata = '0; i_wr = 1'b0;
    i_length = 2'b00; i_signed = 1'b0; i_bus_ready = 1'b1;
    i_bus_rvalid = 1'b0; i_bus_rdata = '0;

    // wr len sgn addr wdata rd0 rd1 | err beats a0 s0 w0 a1 s1 w1 rdata lat
    vecs.push_back(mk(0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 1, 32'h100, 4'h0, 0, 0, 0, 0, 32'hDEADBEEF, 3));
    vecs.push_back(mk(0, 2'd0, 1, 32'h103, 0, 32'h80123456, 0, 0, 1, 32'h100, 4'h0, 0, 0, 0, 0, 32'hFFFFFF80, 3));
    vecs.push_back(mk(0, 2'd0, 0, 32'h103, 0, 32'h80123456, 0, 0, 1, 32'h100, 4'h0, 0, 0, 0, 0, 32'h00000080, 3));
    vecs.push_back(mk(1, 2'd1, 0, 32'h102, 32'h0000ABCD, 0, 0, 0, 1, 32'h100, 4'b1100, 32'hABCD0000, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 2'd1, 1, 32'h102, 0, 32'h7FFF0000, 0, 0, 1, 32'h100, 4'h0, 0, 0, 0, 0, 32'h00007FFF, 3));
    vecs.push_back(mk(0, 2'd1, 1, 32'h100, 0, 32'h12348001, 0, 0, 1, 32'h100, 4'h0, 0, 0, 0, 0, 32'hFFFF8001, 3));
    vecs.push_back(mk(1, 2'd0, 0, 32'h201, 32'hFFFFFFA5, 0, 0, 0, 1, 32'h200, 4'b0010, 32'h0000A500, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 2'd2, 0, 32'h300, 32'h12345678, 0, 0, 0, 1, 32'h300, 4'b1111, 32'h12345678, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 2'd3, 0, 32'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef LSU_MISALIGNED_EN
    vecs.push_back(mk(0, 2'd2, 0, 32'h0FE, 0, 32'h11223344, 32'h55667788, 0, 2, 32'h0FC, 4'h0, 0, 32'h100, 4'h0, 0, 32'h77881122, 5));
    vecs.push_back(mk(1, 2'd2, 0, 32'h103, 32'hAABBCCDD, 0, 0, 0, 2, 32'h100, 4'b1000, 32'hDD000000, 32'h104, 4'b0111, 32'h00AABBCC, 0, 3));
    vecs.push_back(mk(0, 2'd2, 0, 32'hFFFFFFFE, 0, 32'hA1B2C3D4, 32'h01020304, 0, 2, 32'hFFFFFFFC, 4'h0, 0, 32'h00000000, 4'h0, 0, 32'h0304A1B2, 5));
    vecs.push_back(mk(0, 2'd1, 1, 32'h103, 0, 32'h34000000, 32'h000000F2, 0, 2, 32'h100, 4'h0, 0, 32'h104, 4'h0, 0, 32'hFFFFF234, 5));
`else
    vecs.push_back(mk(0, 2'd2, 0, 32'h0FE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2'd1, 0, 32'h103, 32'h0000ABCD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 2'd1, 1, 32'h103, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_valid", o_bus_valid, 1'b0);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_bus_addr", o_bus_addr, 32'h0);
    chk("rst_bus_wr", o_bus_wr, 1'b0);
    chk("rst_bus_wdata", o_bus_wdata, 32'h0);
    chk("rst_bus_strb", o_bus_strb, 4'h0);
    i_rst = 1'b0;
    #1;
    chk("rst_req_ready", o_req_ready, 1'b1);
    $display("txn reset: req_ready=%0d bus_valid=%0d", o_req_ready, o_bus_valid);

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset while waiting for read data; a late rvalid must be ignored
    @(negedge clk);
    i_addr = 32'h100; i_wr = 1'b0; i_length = 2'd2; i_signed = 1'b0; i_req_valid = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("abort_beat_valid", o_bus_valid, 1'b1);
    @(negedge clk);
    chk("abort_wait_bus_valid", o_bus_valid, 1'b0);
    chk("abort_wait_rsp", o_rsp_valid, 1'b0);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    i_bus_rvalid = 1'b1;
    i_bus_rdata = 32'hCAFEF00D;
    #1;
    chk("abort_req_ready", o_req_ready, 1'b1);
    chk("abort_bus_valid", o_bus_valid, 1'b0);
    chk("abort_rsp", o_rsp_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_bus_rvalid = 1'b0;
      i_bus_rdata = '0;
      chk($sformatf("abort_no_rsp_%0d", k), o_rsp_valid, 1'b0);
    end
    $display("txn abort: reset in WAIT0, late rvalid ignored");
    run_vec(100, vecs[0]);

    // Bus stall: ready low for three cycles keeps the beat stable
    @(negedge clk);
    i_addr = 32'h102; i_wdata = 32'h0000ABCD; i_wr = 1'b1; i_length = 2'd1;
    i_signed = 1'b0; i_bus_ready = 1'b0; i_req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      chk($sformatf("stall_c%0d_valid", k), o_bus_valid, 1'b1);
      chk($sformatf("stall_c%0d_addr", k), o_bus_addr, 32'h100);
      chk($sformatf("stall_c%0d_wdata", k), o_bus_wdata, 32'hABCD0000);
      chk($sformatf("stall_c%0d_strb", k), o_bus_strb, 4'b1100);
    end
    @(negedge clk);
    chk("stall_c4_valid", o_bus_valid, 1'b1);
    chk("stall_c4_addr", o_bus_addr, 32'h100);
    i_bus_ready = 1'b1;
    @(negedge clk);
    chk("stall_rsp_valid", o_rsp_valid, 1'b1);
    chk("stall_rsp_err", o_err, 1'b0);
    chk("stall_bus_valid_after", o_bus_valid, 1'b0);
    $display("txn stall: store half 0x102 held 4 cycles then completed rsp=%0d", o_rsp_valid);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
